// File: rtl/sopu_sequencer_if.sv
// sopu_sequencer_if: handshake and control bundle between the SoPU sequencer and its peripherals.
//   master: sequencer side (takes requests/handshakes, drives enables, kernel strobe, status)
//   slave : peripheral/host side (drives requests/handshakes, observes enables and status)
interface sopu_sequencer_if #(
    parameter int KERNEL_BYTES = 9,
    parameter int NUM_CHANNELS = 2
);
    localparam int NK = KERNEL_BYTES * NUM_CHANNELS;
    localparam int AW = NK > 1 ? $clog2(NK) : 1;
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    logic          start;
    logic          reload_kernel;
    logic          uart_rx_valid;
    logic          uart_tx_done;
    logic          ilb_tx_done;
    logic          ilb_rx_valid;
    logic          uart_read_enable;
    logic          uart_send_enable;
    logic          ilb_send_enable;
    logic          ilb_read_enable;
    logic          im_window_shift_enable;
    logic          conv_enable;
    logic          kernel_wr_en;
    logic [AW-1:0] kernel_addr;
    logic [CW-1:0] out_channel;
    logic          busy;
    logic          frame_done;
    modport master (
        input  start, reload_kernel, uart_rx_valid, uart_tx_done, ilb_tx_done, ilb_rx_valid,
        output uart_read_enable, uart_send_enable, ilb_send_enable, ilb_read_enable,
               im_window_shift_enable, conv_enable, kernel_wr_en, kernel_addr, out_channel,
               busy, frame_done
    );
    modport slave (
        output start, reload_kernel, uart_rx_valid, uart_tx_done, ilb_tx_done, ilb_rx_valid,
        input  uart_read_enable, uart_send_enable, ilb_send_enable, ilb_read_enable,
               im_window_shift_enable, conv_enable, kernel_wr_en, kernel_addr, out_channel,
               busy, frame_done
    );
endinterface

// File: rtl/sopu_sequencer.sv
// sopu_sequencer: master sequencer for the SoPU convolution pipeline.
//   clk  : clock
//   rst  : synchronous, active-low reset
//   bus  : sopu_sequencer_if.master -- start/reload requests, UART/ILB handshakes in;
//          one-hot peripheral enables, kernel write strobe/address, output channel,
//          busy and frame_done out.
// Loads NUM_CHANNELS*KERNEL_BYTES kernel bytes when needed, then walks IMG_PIXELS pixels
// through UART RX -> ILB -> window shift -> conv, sending NUM_CHANNELS result bytes for
// every pixel from VALID_START on.
module sopu_sequencer #(
    parameter int KERNEL_BYTES = 9,
    parameter int NUM_CHANNELS = 2,
    parameter int IMG_PIXELS   = 3072,
    parameter int VALID_START  = 66,
    parameter int SHIFT_CYCLES = 2,
    parameter int CONV_CYCLES  = 3
) (
    input logic              clk,
    input logic              rst,
    sopu_sequencer_if.master bus
);
    localparam int NK   = KERNEL_BYTES * NUM_CHANNELS;
    localparam int AW   = NK > 1 ? $clog2(NK) : 1;
    localparam int CW   = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    localparam int PW   = IMG_PIXELS > 1 ? $clog2(IMG_PIXELS) : 1;
    localparam int DMAX = SHIFT_CYCLES > CONV_CYCLES ? SHIFT_CYCLES : CONV_CYCLES;
    localparam int DW   = DMAX > 1 ? $clog2(DMAX) : 1;

    localparam logic [AW-1:0] K_LAST   = AW'(NK - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CHANNELS - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(IMG_PIXELS - 1);
    localparam logic [PW-1:0] PIX_VAL  = PW'(VALID_START);
    localparam logic [DW-1:0] SH_LAST  = DW'(SHIFT_CYCLES - 1);
    localparam logic [DW-1:0] CV_LAST  = DW'(CONV_CYCLES - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD      = 4'd1;
    localparam logic [3:0] S_READ      = 4'd2;
    localparam logic [3:0] S_SEND_ILB  = 4'd3;
    localparam logic [3:0] S_READ_ILB  = 4'd4;
    localparam logic [3:0] S_WIN_SHIFT = 4'd5;
    localparam logic [3:0] S_CONV      = 4'd6;
    localparam logic [3:0] S_SEND_UART = 4'd7;
    localparam logic [3:0] S_NEXT      = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [AW-1:0] kctr_q, kctr_d;
    logic [AW-1:0] kaddr_q, kaddr_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [DW-1:0] dly_q, dly_d;
    logic          kwr_q, kwr_d;
    logic          loaded_q, loaded_d;
    logic          pend_q, pend_d;

    always_comb begin
        state_d  = state_q;
        kctr_d   = kctr_q;
        kaddr_d  = kaddr_q;
        pix_d    = pix_q;
        ch_d     = ch_q;
        dly_d    = dly_q;
        kwr_d    = 1'b0;
        loaded_d = loaded_q;
        // a reload request is remembered in every state and only acted on at the next start
        pend_d   = pend_q | bus.reload_kernel;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = (!loaded_q || pend_d) ? S_LOAD : S_READ;
                kctr_d  = '0;
                pix_d   = '0;
                ch_d    = '0;
                dly_d   = '0;
            end
            S_LOAD: if (bus.uart_rx_valid) begin
                kwr_d   = 1'b1;
                kaddr_d = kctr_q;
                kctr_d  = kctr_q + 1'b1;
                if (kctr_q == K_LAST) begin
                    loaded_d = 1'b1;
                    // a request arriving on the final byte still counts for the next frame
                    pend_d   = bus.reload_kernel;
                    state_d  = S_READ;
                end
            end
            S_READ:     state_d = bus.uart_rx_valid ? S_SEND_ILB : state_q;
            S_SEND_ILB: state_d = bus.ilb_tx_done ? S_READ_ILB : state_q;
            S_READ_ILB: state_d = bus.ilb_rx_valid ? S_WIN_SHIFT : state_q;
            S_WIN_SHIFT: begin
                dly_d   = (dly_q == SH_LAST) ? '0 : dly_q + 1'b1;
                state_d = (dly_q == SH_LAST) ? S_CONV : state_q;
            end
            S_CONV: if (dly_q == CV_LAST) begin
                dly_d   = '0;
                ch_d    = '0;
                state_d = (pix_q >= PIX_VAL) ? S_SEND_UART : S_NEXT;
            end else begin
                dly_d = dly_q + 1'b1;
            end
            S_SEND_UART: if (bus.uart_tx_done) begin
                ch_d    = (ch_q == CH_LAST) ? ch_q : ch_q + 1'b1;
                state_d = (ch_q == CH_LAST) ? S_NEXT : state_q;
            end
            S_NEXT: begin
                pix_d   = (pix_q == PIX_LAST) ? pix_q : pix_q + 1'b1;
                state_d = (pix_q == PIX_LAST) ? S_IDLE : S_READ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            kctr_q   <= '0;
            kaddr_q  <= '0;
            pix_q    <= '0;
            ch_q     <= '0;
            dly_q    <= '0;
            kwr_q    <= 1'b0;
            loaded_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kctr_q   <= kctr_d;
            kaddr_q  <= kaddr_d;
            pix_q    <= pix_d;
            ch_q     <= ch_d;
            dly_q    <= dly_d;
            kwr_q    <= kwr_d;
            loaded_q <= loaded_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.uart_read_enable       = (state_q == S_LOAD) || (state_q == S_READ);
    assign bus.ilb_send_enable        = state_q == S_SEND_ILB;
    assign bus.ilb_read_enable        = state_q == S_READ_ILB;
    assign bus.im_window_shift_enable = state_q == S_WIN_SHIFT;
    assign bus.conv_enable            = state_q == S_CONV;
    assign bus.uart_send_enable       = state_q == S_SEND_UART;
    assign bus.kernel_wr_en           = kwr_q;
    assign bus.kernel_addr            = kaddr_q;
    assign bus.out_channel            = ch_q;
    assign bus.busy                   = state_q != S_IDLE;
    assign bus.frame_done             = (state_q == S_NEXT) && (pix_q == PIX_LAST);
endmodule

// File: tb/tb_sopu_sequencer.sv
// tb_sopu_sequencer: randomized self-checking bench for sopu_sequencer against a procedural frame model.
module tb_sopu_sequencer;
    localparam int KB = 9, NC = 2, IMG = 16, VS = 10, SH = 2, CV = 3, NK = KB * NC;
    localparam int EN_OFF = 0, EN_RD = 1, EN_ILBS = 2, EN_ILBR = 3, EN_SH = 4, EN_CV = 5, EN_SND = 6, EN_NEXT = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    sopu_sequencer_if #(.KERNEL_BYTES(KB), .NUM_CHANNELS(NC)) bus ();
    sopu_sequencer #(
        .KERNEL_BYTES(KB), .NUM_CHANNELS(NC), .IMG_PIXELS(IMG),
        .VALID_START(VS), .SHIFT_CYCLES(SH), .CONV_CYCLES(CV)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: walks a frame as a sequence of waits ----------------
    bit e_rd, e_ilbs, e_ilbr, e_sh, e_cv, e_snd, e_busy, e_fd, e_kwr;
    int e_kaddr, e_ch;
    bit m_loaded, m_pend, m_abort, m_rst, m_live;
    bit s_start, s_reload, s_rx, s_tx, s_it, s_ir;

    task automatic set_en(input int w);
        e_rd = (w == EN_RD); e_ilbs = (w == EN_ILBS); e_ilbr = (w == EN_ILBR);
        e_sh = (w == EN_SH); e_cv = (w == EN_CV); e_snd = (w == EN_SND);
        e_busy = (w != EN_OFF);
    endtask

    task automatic mtick();
        @(posedge clk);
        e_kwr = 0;
        m_rst = 0;
        if (!rst) begin
            m_abort = 1; m_rst = 1; m_live = 1; m_loaded = 0; m_pend = 0;
            set_en(EN_OFF); e_fd = 0; e_kaddr = 0; e_ch = 0;
            s_start = 0; s_reload = 0; s_rx = 0; s_tx = 0; s_it = 0; s_ir = 0;
        end else begin
            s_start = bus.start; s_reload = bus.reload_kernel;
            s_rx = bus.uart_rx_valid; s_tx = bus.uart_tx_done;
            s_it = bus.ilb_tx_done; s_ir = bus.ilb_rx_valid;
            if (s_reload) m_pend = 1;
        end
    endtask

    function automatic bit sel(input int i);
        return i == 0 ? s_rx : i == 1 ? s_it : i == 2 ? s_ir : s_tx;
    endfunction

    task automatic m_wait(input int i);
        do mtick(); while (!m_abort && !sel(i));
    endtask

    task automatic m_frame();
        e_ch = 0;
        if (!m_loaded || m_pend) begin
            set_en(EN_RD);
            for (int k = 0; k < NK; k++) begin
                m_wait(0);
                if (m_abort) return;
                e_kwr = 1;
                e_kaddr = k;
            end
            m_loaded = 1;
            m_pend = s_reload;
        end
        for (int p = 0; p < IMG; p++) begin
            set_en(EN_RD);   m_wait(0); if (m_abort) return;
            set_en(EN_ILBS); m_wait(1); if (m_abort) return;
            set_en(EN_ILBR); m_wait(2); if (m_abort) return;
            set_en(EN_SH);
            repeat (SH) begin mtick(); if (m_abort) return; end
            set_en(EN_CV);
            repeat (CV) begin mtick(); if (m_abort) return; end
            if (p >= VS) begin
                set_en(EN_SND);
                for (int c = 0; c < NC; c++) begin
                    e_ch = c;
                    m_wait(3);
                    if (m_abort) return;
                end
            end
            set_en(EN_NEXT);
            e_fd = (p == IMG - 1);
            mtick();
            if (m_abort) return;
            e_fd = 0;
        end
        set_en(EN_OFF);
    endtask

    initial begin
        forever begin
            mtick();
            if (!m_abort && s_start) m_frame();
            m_abort = 0;
        end
    end

    // ---------------- compare + event counters, #1 after each active edge ----------------
    int cnt_kwr, cnt_sh, cnt_cv, cnt_txc, cnt_fd, cnt_ilbs, cnt_ilbr, cnt_sndr;
    bit prev_snd, prev_ilbr;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_live) begin
                chk("uart_read_enable", bus.uart_read_enable, e_rd);
                chk("ilb_send_enable", bus.ilb_send_enable, e_ilbs);
                chk("ilb_read_enable", bus.ilb_read_enable, e_ilbr);
                chk("im_window_shift_enable", bus.im_window_shift_enable, e_sh);
                chk("conv_enable", bus.conv_enable, e_cv);
                chk("uart_send_enable", bus.uart_send_enable, e_snd);
                chk("busy", bus.busy, e_busy);
                chk("frame_done", bus.frame_done, e_fd);
                chk("kernel_wr_en", bus.kernel_wr_en, e_kwr);
                if (e_kwr || m_rst) chk("kernel_addr", bus.kernel_addr, e_kaddr);
                if (e_snd || m_rst) chk("out_channel", bus.out_channel, e_ch);
            end
            if (bus.kernel_wr_en) begin
                chk("kernel_addr_seq", bus.kernel_addr, cnt_kwr);
                cnt_kwr++;
            end
            cnt_sh += bus.im_window_shift_enable;
            cnt_cv += bus.conv_enable;
            cnt_fd += bus.frame_done;
            cnt_ilbs += bus.ilb_send_enable;
            cnt_ilbr += (bus.ilb_read_enable && !prev_ilbr);
            cnt_sndr += (bus.uart_send_enable && !prev_snd);
            cnt_txc += (prev_snd && bus.uart_tx_done);
            prev_snd = bus.uart_send_enable;
            prev_ilbr = bus.ilb_read_enable;
        end
    end

    // ---------------- peripheral responder ----------------
    int dmin[4], dmax[4], dl[4], rc[4];
    bit spur;

    function automatic bit resp(input int i, input logic en);
        if (!en) begin
            rc[i] = 0;
            return spur && ($urandom_range(0, 99) < 15);
        end
        if (rc[i] >= dl[i]) begin
            rc[i] = 0;
            dl[i] = $urandom_range(dmin[i], dmax[i]);
            return 1;
        end
        rc[i]++;
        return 0;
    endfunction

    initial begin
        bus.uart_rx_valid = 0; bus.ilb_tx_done = 0; bus.ilb_rx_valid = 0; bus.uart_tx_done = 0;
        forever begin
            @(negedge clk);
            bus.uart_rx_valid = resp(0, bus.uart_read_enable);
            bus.ilb_tx_done   = resp(1, bus.ilb_send_enable);
            bus.ilb_rx_valid  = resp(2, bus.ilb_read_enable);
            bus.uart_tx_done  = resp(3, bus.uart_send_enable);
        end
    end

    // ---------------- directed + random sequence ----------------
    task automatic set_dly(input int i, input int lo, input int hi);
        dmin[i] = lo; dmax[i] = hi; dl[i] = lo;
    endtask

    task automatic clr();
        cnt_kwr = 0; cnt_sh = 0; cnt_cv = 0; cnt_txc = 0; cnt_fd = 0; cnt_ilbs = 0; cnt_ilbr = 0; cnt_sndr = 0;
    endtask

    task automatic pulse_start(input bit rl);
        @(negedge clk);
        bus.start = 1; bus.reload_kernel = rl;
        @(negedge clk);
        bus.start = 0; bus.reload_kernel = 0;
    endtask

    task automatic run_fd(input int budget, input bit rl);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            bus.reload_kernel = rl && ($urandom_range(0, 99) < 3);
            @(posedge clk);
            #1;
            ok = bus.frame_done;
        end
        @(negedge clk);
        bus.reload_kernel = 0;
        chk("frame_done_within_budget", ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.start = 0; bus.reload_kernel = 0; spur = 0;
        for (int i = 0; i < 4; i++) set_dly(i, 0, 0);
        clr();
        repeat (3) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_kernel_wr_en", bus.kernel_wr_en, 0);
        chk("reset_uart_read_enable", bus.uart_read_enable, 0);
        chk("reset_out_channel", bus.out_channel, 0);
        rst = 1;
        // kernel load + full frame with immediate handshakes
        clr(); pulse_start(0); run_fd(3000, 0);
        chk("load_kwr_count", cnt_kwr, 18);
        chk("frame_shift_cycles", cnt_sh, 32);
        chk("frame_conv_cycles", cnt_cv, 48);
        chk("frame_tx_done_consumed", cnt_txc, 12);
        chk("frame_done_pulses", cnt_fd, 1);
        // second frame skips the load; mid-frame reload only affects the following frame
        clr(); pulse_start(0);
        repeat (30) @(negedge clk);
        bus.reload_kernel = 1;
        @(negedge clk);
        bus.reload_kernel = 0;
        run_fd(3000, 0);
        chk("no_reload_kwr_count", cnt_kwr, 0);
        chk("no_reload_frame_done", cnt_fd, 1);
        clr(); pulse_start(0); run_fd(3000, 0);
        chk("pending_reload_kwr_count", cnt_kwr, 18);
        // stray handshakes while loading and convolving; start+reload together forces a load
        spur = 1;
        for (int i = 0; i < 4; i++) set_dly(i, 0, 2);
        clr(); pulse_start(1); run_fd(3000, 0);
        chk("spurious_kwr_count", cnt_kwr, 18);
        chk("spurious_tx_done_consumed", cnt_txc, 12);
        spur = 0;
        for (int i = 0; i < 4; i++) set_dly(i, 0, 0);
        // reset during SEND_UART of pixel 12 aborts the frame and forgets the kernel
        set_dly(3, 3, 3);
        clr(); pulse_start(0);
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = (cnt_sndr == 3) && bus.uart_send_enable;
        end
        chk("reached_pixel12_send", seen, 1);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_uart_send_enable", bus.uart_send_enable, 0);
        chk("abort_out_channel", bus.out_channel, 0);
        set_dly(3, 0, 0);
        clr(); pulse_start(0); run_fd(3000, 0);
        chk("post_reset_kwr_count", cnt_kwr, 18);
        // start held 40 cycles and a 5-cycle ILB stall on every pixel
        set_dly(1, 5, 5);
        clr();
        @(negedge clk);
        bus.start = 1;
        repeat (40) @(negedge clk);
        bus.start = 0;
        run_fd(5000, 0);
        repeat (20) @(negedge clk);
        chk("held_start_frames", cnt_fd, 1);
        chk("held_start_busy_after", bus.busy, 0);
        chk("stall_ilb_send_cycles", cnt_ilbs, 96);
        chk("stall_read_ilb_entries", cnt_ilbr, 16);
        chk("held_start_kwr_count", cnt_kwr, 0);
        set_dly(1, 0, 0);
        // randomized frames: delays, stray pulses, reload requests at any time
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 4; i++) set_dly(i, 0, $urandom_range(0, 3));
            spur = $urandom_range(0, 1);
            clr(); pulse_start($urandom_range(0, 1)); run_fd(5000, 1);
            chk("random_frame_done_pulses", cnt_fd, 1);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        spur = 0;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sopu_sequencer.md
Name: sopu_sequencer

Overview:
- Parametrised master sequencer for the SoPU convolution pipeline.
- Loads a multi-channel kernel over UART, then streams a frame pixel by pixel through UART RX, the image line buffer (ILB), window shift and convolution.
- Sends NUM_CHANNELS result bytes per valid output over UART TX.
- Sits between the UART/ILB peripherals and the window/conv datapath; adds frame start/done, kernel reload and per-channel output sequencing.

Parameters:
- KERNEL_BYTES, 9: kernel bytes per channel.
- NUM_CHANNELS, 2: output channels; kernel bytes and result bytes are both per channel.
- IMG_PIXELS, 3072: pixels per frame.
- VALID_START, 66: zero-based pixel index of the first pixel whose conv result is valid and sent.
- SHIFT_CYCLES, 2: cycles spent in WIN_SHIFT, ≥1.
- CONV_CYCLES, 3: cycles spent in CONV, ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  frame start request, sampled in IDLE only
- reload_kernel  in  1  one-cycle request to reload the kernel before the next frame
- uart_rx_valid  in  1  one-cycle pulse: UART byte received
- uart_tx_done  in  1  one-cycle pulse: UART byte sent
- ilb_tx_done  in  1  ILB accepted the pixel
- ilb_rx_valid  in  1  ILB window column ready
- uart_read_enable  out  1
- uart_send_enable  out  1
- ilb_send_enable  out  1
- ilb_read_enable  out  1
- im_window_shift_enable  out  1
- conv_enable  out  1
- kernel_wr_en  out  1  one-cycle kernel byte write strobe
- kernel_addr  out  clog2(KERNEL_BYTES*NUM_CHANNELS)  kernel byte address
- out_channel  out  max(1,clog2(NUM_CHANNELS))  channel whose result is being sent
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse after the last pixel is processed

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; all outputs 0; all counters 0; kernel_loaded=0; reload_pending=0. Reset aborts any operation immediately.
- Peripheral enables are Moore decodes of the state register:
  - LOAD_KERNEL, READ_PIXEL → uart_read_enable
  - SEND_ILB → ilb_send_enable
  - READ_ILB → ilb_read_enable
  - WIN_SHIFT → im_window_shift_enable
  - CONV → conv_enable
  - SEND_UART → uart_send_enable
  - At most one enable is high in any cycle.
- IDLE:
  - On start, go to LOAD_KERNEL if (!kernel_loaded || reload_pending), else READ_PIXEL.
  - Clear pix_ctr, kctr, out_channel, and the delay counters on exit.
- LOAD_KERNEL:
  - Each uart_rx_valid gives kernel_wr_en=1 for exactly the next cycle, with kernel_addr=kctr (registered); then kctr increments.
  - On the byte where kctr==KERNEL_BYTES*NUM_CHANNELS-1: set kernel_loaded=1, clear reload_pending, go to READ_PIXEL.
- READ_PIXEL: on uart_rx_valid go to SEND_ILB.
- SEND_ILB: on ilb_tx_done go to READ_ILB.
- READ_ILB: on ilb_rx_valid go to WIN_SHIFT.
- WIN_SHIFT: stay exactly SHIFT_CYCLES cycles, then go to CONV.
- CONV: stay exactly CONV_CYCLES cycles, then:
  - if pix_ctr ≥ VALID_START, go to SEND_UART with out_channel=0;
  - else go to NEXT.
- SEND_UART:
  - On uart_tx_done: if out_channel==NUM_CHANNELS-1, go to NEXT; else increment out_channel and stay.
  - uart_send_enable stays high across channel changes.
- NEXT (single cycle, all enables 0):
  - If pix_ctr==IMG_PIXELS-1: frame_done=1 for 1 cycle, go to IDLE; kernel_loaded is kept.
  - Else increment pix_ctr and go to READ_PIXEL.
- Counters are sized to their max value; no wrap occurs within a frame. pix_ctr width is clog2(IMG_PIXELS).
- reload_kernel:
  - Sets reload_pending in any state, including while busy.
  - Takes effect only at the next start; it never interrupts a frame.
  - If it coincides with reset, reset wins.
- start while busy is ignored; it is not queued.
- Handshake inputs arriving in a state that does not wait on them are ignored:
  - uart_rx_valid outside LOAD_KERNEL/READ_PIXEL
  - uart_tx_done outside SEND_UART
  - and likewise for the ILB inputs.
- Simultaneous start and reload_kernel in IDLE: go to LOAD_KERNEL.

Test Plan:
1. Parameters: KERNEL_BYTES=9, NUM_CHANNELS=2, IMG_PIXELS=16, VALID_START=10, SHIFT_CYCLES=2, CONV_CYCLES=3. Reset, then start, then 18 uart_rx_valid pulses → 18 kernel_wr_en pulses with kernel_addr 0..17; next state READ_PIXEL; kernel_loaded=1.
2. Full 16-pixel frame with immediate handshakes:
   - im_window_shift_enable high for exactly 2 cycles per pixel; conv_enable high for exactly 3 cycles per pixel.
   - uart_send_enable appears only for pixels 10..15; 12 uart_tx_done pulses consumed, with out_channel toggling 0,1.
   - frame_done pulses once; busy falls the following cycle.
3. Second start without reload → goes directly to READ_PIXEL, no kernel_wr_en. reload_kernel pulsed mid-frame → frame completes normally; the next start enters LOAD_KERNEL.
4. uart_tx_done, ilb_tx_done and ilb_rx_valid injected during LOAD_KERNEL and CONV → no state change, no counter change.
5. rst=0 asserted in SEND_UART at pixel 12 → next cycle all outputs 0, IDLE. A subsequent start reloads the kernel (kernel_loaded was cleared).
6. start held high for 40 cycles during a frame → exactly one frame runs. Delayed ilb_tx_done (5-cycle stall) → ilb_send_enable held for the whole stall, exactly one transition to READ_ILB.
